// File: rtl/hiscore_ioctl_driver_pkg.sv
// Shared definitions for the hiscore ioctl initiator: FSM states, ioctl
// index constants and the ioctl address width.
package hs_ioctl_pkg;

    localparam logic [7:0] HS_CONFIGINDEX = 8'd3;
    localparam logic [7:0] HS_DUMPINDEX   = 8'd4;

    localparam int unsigned IOCTL_ADDR_W = 25;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRE,
        ST_SETUP,
        ST_FETCH,
        ST_LOAD,
        ST_WR,
        ST_GAP,
        ST_ADDR,
        ST_SETTLE,
        ST_POST1,
        ST_POST2
    } hs_ioctl_state_t;

endpackage

// File: rtl/hiscore_ioctl_driver_if.sv
// hps_io-style ioctl bus. The master modport is the transfer initiator,
// the slave modport is the target (e.g. the hiscore block).
interface hiscore_ioctl_driver_if;
    import hs_ioctl_pkg::*;

    logic                    ioctl_download;
    logic                    ioctl_upload;
    logic                    ioctl_wr;
    logic [IOCTL_ADDR_W-1:0] ioctl_addr;
    logic [7:0]              ioctl_dout;
    logic [7:0]              ioctl_index;
    logic [7:0]              ioctl_din;

    modport master (
        output ioctl_download,
        output ioctl_upload,
        output ioctl_wr,
        output ioctl_addr,
        output ioctl_dout,
        output ioctl_index,
        input  ioctl_din
    );

    modport slave (
        input  ioctl_download,
        input  ioctl_upload,
        input  ioctl_wr,
        input  ioctl_addr,
        input  ioctl_dout,
        input  ioctl_index,
        output ioctl_din
    );

endinterface

// File: rtl/hiscore_ioctl_driver_timer.sv
// Loadable down-counter with a zero flag; times the write gap and the
// read settle window. Holds at zero until reloaded.
module hs_ioctl_timer #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hiscore_ioctl_driver.sv
// ioctl transfer initiator: takes a download/upload command and plays the
// hps_io side of the ioctl protocol, streaming bytes from a local source
// (download) or collecting ioctl_din into a byte sink (upload).
module hiscore_ioctl_driver
    import hs_ioctl_pkg::*;
#(
    parameter int unsigned LEN_WIDTH = 16,
    parameter int unsigned WR_GAP    = 4,
    parameter int unsigned RD_SETTLE = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_upload,
    input  logic [7:0]           cmd_index,
    input  logic [LEN_WIDTH-1:0] cmd_len,

    output logic                 src_req,
    output logic [LEN_WIDTH-1:0] src_addr,
    input  logic [7:0]           src_data,

    output logic                 sink_valid,
    output logic [LEN_WIDTH-1:0] sink_addr,
    output logic [7:0]           sink_data,

    hiscore_ioctl_driver_if.master ioctl,

    output logic                 busy,
    output logic                 done
);

    localparam int unsigned TMR_MAX = (WR_GAP > RD_SETTLE) ? WR_GAP : RD_SETTLE;
    localparam int unsigned TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] GAP_LOAD    = TMR_W'(WR_GAP - 1);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(RD_SETTLE - 1);

    hs_ioctl_state_t      state;
    logic                 up_r;
    logic                 empty_r;
    logic [LEN_WIDTH-1:0] last_k;
    logic [LEN_WIDTH-1:0] k;

    logic                 tmr_load;
    logic [TMR_W-1:0]     tmr_val;
    logic [TMR_W-1:0]     tmr_count;
    logic                 tmr_zero;
    logic                 settle_sample;

    // Timer is reloaded on the WR cycle (gap) and on the ADDR cycle (settle).
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = GAP_LOAD;
        if (state == ST_WR) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_LOAD;
        end else if (state == ST_ADDR) begin
            tmr_load = 1'b1;
            tmr_val  = SETTLE_LOAD;
        end
    end

    hs_ioctl_timer #(.WIDTH(TMR_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .count    (tmr_count),
        .zero     (tmr_zero)
    );

    // Outputs are registered, so ioctl_din is captured on the edge that
    // opens the last settle cycle; with a 1-cycle window that edge is the
    // one leaving ADDR.
    assign settle_sample = ((state == ST_ADDR) && (RD_SETTLE == 1)) ||
                           ((state == ST_SETTLE) && (tmr_count == TMR_W'(1)));

    // Transfer sequencer; every output is set on the edge entering the
    // cycle it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state                <= ST_IDLE;
            up_r                 <= 1'b0;
            empty_r              <= 1'b0;
            last_k               <= '0;
            k                    <= '0;
            cmd_ready            <= 1'b0;
            src_req              <= 1'b0;
            src_addr             <= '0;
            sink_valid           <= 1'b0;
            sink_addr            <= '0;
            sink_data            <= '0;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            ioctl.ioctl_download <= 1'b0;
            ioctl.ioctl_upload   <= 1'b0;
            ioctl.ioctl_wr       <= 1'b0;
            ioctl.ioctl_addr     <= '0;
            ioctl.ioctl_dout     <= '0;
            ioctl.ioctl_index    <= '0;
        end else begin
            src_req        <= 1'b0;
            sink_valid     <= 1'b0;
            ioctl.ioctl_wr <= 1'b0;
            done           <= 1'b0;

            if (settle_sample) begin
                sink_valid <= 1'b1;
                sink_addr  <= k;
                sink_data  <= ioctl.ioctl_din;
            end

            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        up_r              <= cmd_upload;
                        empty_r           <= (cmd_len == '0);
                        last_k            <= cmd_len - LEN_WIDTH'(1);
                        ioctl.ioctl_index <= cmd_index;
                        busy              <= 1'b1;
                        cmd_ready         <= 1'b0;
                        state             <= ST_PRE;
                    end else begin
                        cmd_ready <= 1'b1;
                    end
                end
                ST_PRE: begin
                    ioctl.ioctl_download <= !up_r;
                    ioctl.ioctl_upload   <= up_r;
                    ioctl.ioctl_addr     <= '0;
                    k                    <= '0;
                    state                <= ST_SETUP;
                end
                ST_SETUP: begin
                    if (empty_r) begin
                        ioctl.ioctl_download <= 1'b0;
                        ioctl.ioctl_upload   <= 1'b0;
                        state                <= ST_POST1;
                    end else if (up_r) begin
                        state <= ST_ADDR;
                    end else begin
                        src_req  <= 1'b1;
                        src_addr <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ioctl.ioctl_addr <= IOCTL_ADDR_W'(k);
                    state            <= ST_LOAD;
                end
                ST_LOAD: begin
                    // src_data is valid in this cycle; it is launched with the strobe.
                    ioctl.ioctl_dout <= src_data;
                    ioctl.ioctl_wr   <= 1'b1;
                    state            <= ST_WR;
                end
                ST_WR: begin
                    state <= ST_GAP;
                end
                ST_GAP: begin
                    if (tmr_zero) begin
                        if (k == last_k) begin
                            ioctl.ioctl_download <= 1'b0;
                            state                <= ST_POST1;
                        end else begin
                            k        <= k + LEN_WIDTH'(1);
                            src_req  <= 1'b1;
                            src_addr <= k + LEN_WIDTH'(1);
                            state    <= ST_FETCH;
                        end
                    end
                end
                ST_ADDR: begin
                    state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        if (k == last_k) begin
                            ioctl.ioctl_upload <= 1'b0;
                            state              <= ST_POST1;
                        end else begin
                            k                <= k + LEN_WIDTH'(1);
                            ioctl.ioctl_addr <= IOCTL_ADDR_W'(k + LEN_WIDTH'(1));
                            state            <= ST_ADDR;
                        end
                    end
                end
                ST_POST1: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_POST2;
                end
                ST_POST2: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hiscore_ioctl_driver.sv
// Bench for hiscore_ioctl_driver: directed and random transfers checked
// cycle by cycle against the published timing formulas.
module tb_hiscore_ioctl_driver;
    import hs_ioctl_pkg::*;

    localparam int unsigned LW  = 16;
    localparam int unsigned GAP = 4;
    localparam int unsigned SET = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_upload;
    logic [7:0]    cmd_index;
    logic [LW-1:0] cmd_len;
    logic          src_req;
    logic [LW-1:0] src_addr;
    logic [7:0]    src_data;
    logic          sink_valid;
    logic [LW-1:0] sink_addr;
    logic [7:0]    sink_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    // byte source contents, target stub storage, expected target contents
    logic [7:0] src_mem [0:255];
    logic [7:0] tgt_mem [0:255];
    bit         tgt_valid [0:255];
    logic [7:0] mdl_mem [0:255];
    bit         mdl_valid [0:255];
    logic [7:0] din_pipe;

    hiscore_ioctl_driver_if io();

    hiscore_ioctl_driver #(
        .LEN_WIDTH (LW),
        .WR_GAP    (GAP),
        .RD_SETTLE (SET)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_upload (cmd_upload),
        .cmd_index  (cmd_index),
        .cmd_len    (cmd_len),
        .src_req    (src_req),
        .src_addr   (src_addr),
        .src_data   (src_data),
        .sink_valid (sink_valid),
        .sink_addr  (sink_addr),
        .sink_data  (sink_data),
        .ioctl      (io),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // synchronous byte source: data one cycle after the request
    always @(posedge clk) begin
        if (src_req) src_data <= src_mem[src_addr[7:0]];
    end

    // target stub: stores dump downloads, answers reads with 2-cycle latency;
    // unwritten locations read back as addr + 0x20
    always @(posedge clk) begin
        if (io.ioctl_wr && io.ioctl_download && io.ioctl_index == HS_DUMPINDEX) begin
            tgt_mem[io.ioctl_addr[7:0]]   <= io.ioctl_dout;
            tgt_valid[io.ioctl_addr[7:0]] <= 1'b1;
        end
        din_pipe     <= tgt_valid[io.ioctl_addr[7:0]] ? tgt_mem[io.ioctl_addr[7:0]]
                                                      : io.ioctl_addr[7:0] + 8'h20;
        io.ioctl_din <= din_pipe;
    end

    function automatic logic [7:0] exp_up(input int unsigned a);
        logic [7:0] a8;
        a8 = a[7:0];
        return mdl_valid[a8] ? mdl_mem[a8] : a8 + 8'h20;
    endfunction

    function automatic logic [127:0] all_outs();
        return 128'({cmd_ready, src_req, src_addr, sink_valid, sink_addr, sink_data,
                     io.ioctl_download, io.ioctl_upload, io.ioctl_wr, io.ioctl_addr,
                     io.ioctl_dout, io.ioctl_index, busy, done});
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one command and check every cycle up to done against the
    // timing formulas. abort_c != 0 pulls reset in that cycle.
    task automatic run_cmd(input bit up, input logic [7:0] idx, input int unsigned n,
                           input bit keep, input int unsigned abort_c);
        int unsigned p, d, wait_n, kk;
        bit e_dl, e_ul, e_wr, e_sreq, e_sv;
        logic [7:0] e_vec, o_vec;
        wait_n = 0;
        while (cmd_ready !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        check("cmd_ready_before_cmd", 128'(cmd_ready), 128'(1));
        if (cmd_ready !== 1'b1) return;
        cmd_valid  = 1'b1;
        cmd_upload = up;
        cmd_index  = idx;
        cmd_len    = LW'(n);
        p = up ? 1 + SET : 3 + GAP;
        d = 4 + n * p;
        for (int unsigned c = 1; c <= d; c++) begin
            @(negedge clk);
            if (c == 1 && !keep) begin
                cmd_valid  = 1'b0;
                cmd_upload = 1'($urandom);
                cmd_index  = 8'($urandom);
                cmd_len    = LW'($urandom);
            end
            e_dl   = !up && c >= 2 && c < 3 + n * p;
            e_ul   = up && c >= 2 && c < 3 + n * p;
            e_wr   = !up && c >= 5 && (c - 5) % p == 0 && (c - 5) / p < n;
            e_sreq = !up && c >= 3 && (c - 3) % p == 0 && (c - 3) / p < n;
            e_sv   = up && c >= 3 + SET && (c - 3 - SET) % p == 0 && (c - 3 - SET) / p < n;
            e_vec  = {e_dl, e_ul, e_wr, e_sreq, e_sv, c == d, c < d, 1'b0};
            o_vec  = {io.ioctl_download, io.ioctl_upload, io.ioctl_wr, src_req,
                      sink_valid, done, busy, cmd_ready};
            check("ctrl", 128'(o_vec), 128'(e_vec));
            check("index", 128'(io.ioctl_index), 128'(idx));
            if (c >= 2) begin
                if (up) kk = (c >= 3) ? (c - 3) / p : 0;
                else    kk = (c >= 4) ? (c - 4) / p : 0;
                if (n == 0) kk = 0;
                else if (kk > n - 1) kk = n - 1;
                check("addr", 128'(io.ioctl_addr), 128'(kk));
            end
            if (!up && n > 0 && c >= 5) begin
                kk = (c - 5) / p;
                if (kk > n - 1) kk = n - 1;
                check("dout", 128'(io.ioctl_dout), 128'(src_mem[kk[7:0]]));
            end
            if (e_sreq) check("src_addr", 128'(src_addr), 128'((c - 3) / p));
            if (e_sv) begin
                kk = (c - 3 - SET) / p;
                check("sink_addr", 128'(sink_addr), 128'(kk));
                check("sink_data", 128'(sink_data), 128'(exp_up(kk)));
            end
            if (abort_c == c) begin
                reset_n = 1'b0;
                #1;
                check("abort_outputs_zero", all_outs(), 128'(0));
                return;
            end
        end
        if (!up && idx == HS_DUMPINDEX) begin
            for (int unsigned i = 0; i < n; i++) begin
                mdl_valid[i[7:0]] = 1'b1;
                mdl_mem[i[7:0]]   = src_mem[i[7:0]];
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] cfg [0:15];
        cfg = '{8'h00, 8'h00, 8'h43, 8'h0B, 8'h0F, 8'h10, 8'h01, 8'h00,
                8'h00, 8'h00, 8'h43, 8'h1B, 8'h02, 8'h00, 8'hFF, 8'h00};
        reset_n    = 1'b0;
        cmd_valid  = 1'b0;
        cmd_upload = 1'b0;
        cmd_index  = '0;
        cmd_len    = '0;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 128'(0));
        reset_n = 1'b1;
        #1 check("ready_low_at_release", 128'(cmd_ready), 128'(0));
        @(negedge clk);
        check("idle_ready", 128'(cmd_ready), 128'(1));

        // config download, 8 bytes
        for (int i = 0; i < 8; i++) src_mem[i] = cfg[i];
        run_cmd(1'b0, HS_CONFIGINDEX, 8, 1'b0, 0);
        @(negedge clk);
        check("idle_hold", 128'({io.ioctl_index, io.ioctl_addr, io.ioctl_dout,
                                 io.ioctl_download, io.ioctl_upload, io.ioctl_wr}),
              128'({8'd3, 25'd7, 8'h00, 3'b000}));

        // upload of 3 bytes from the addr+0x20 pattern
        run_cmd(1'b1, HS_DUMPINDEX, 3, 1'b0, 0);

        // zero-length download
        run_cmd(1'b0, 8'h05, 0, 1'b0, 0);

        // cmd_valid held high across a whole transfer
        run_cmd(1'b1, 8'h02, 2, 1'b1, 0);
        @(negedge clk);
        check("held_second_ready", 128'({cmd_ready, busy}), 128'(2'b10));
        run_cmd(1'b1, 8'h02, 2, 1'b0, 0);

        // reset during the WR cycle of byte 2
        for (int i = 0; i < 8; i++) src_mem[i] = 8'($urandom);
        run_cmd(1'b0, HS_CONFIGINDEX, 4, 1'b0, 5 + 2 * (3 + GAP));
        repeat (3) begin
            @(negedge clk);
            check("in_reset_zero", all_outs(), 128'(0));
        end
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_abort", 128'(cmd_ready), 128'(1));
        src_mem[0] = 8'($urandom);
        run_cmd(1'b0, HS_CONFIGINDEX, 1, 1'b0, 0);

        // random transfers
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 16; i++) src_mem[i] = 8'($urandom);
            run_cmd(1'($urandom), 8'($urandom_range(0, 7)), $urandom_range(0, 10), 1'b0, 0);
        end

        // config then dump download, then upload of the dump
        for (int i = 0; i < 16; i++) src_mem[i] = cfg[i];
        run_cmd(1'b0, HS_CONFIGINDEX, 16, 1'b0, 0);
        for (int i = 0; i < 12; i++) src_mem[i] = 8'($urandom);
        run_cmd(1'b0, HS_DUMPINDEX, 12, 1'b0, 0);
        run_cmd(1'b1, HS_DUMPINDEX, 12, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
